cim_macro_driver: RTL and testbench

Host-side sequencer for the 64-column compute-in-memory macro. It takes host commands through a valid/ready handshake and does two jobs:
- **Row write:** turns a command into a timed write of one 64-bit weight row.
- **Bit-serial compute:** drives ACT_BITS input bit-planes onto In_B, samples the macro's 64 DOut lines once per plane, and shift-accumulates one ACT_BITS-wide result per column.

It sits between the accelerator control path and the macro. It is the only agent driving the macro's WE/WL/BL/BLB/In_B/Addr/wb pins.

---
 rtl/cim_macro_driver_if.sv | 26 ++
 rtl/cim_macro_driver.sv | 145 ++++++++++++++
 tb/tb_cim_macro_driver.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cim_macro_driver_if.sv
// Host command / result handshake bundle for the CIM macro driver.
interface cim_macro_driver_if #(
    parameter int ACT_BITS = 4
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_op;
    logic [6:0]               cmd_row;
    logic [63:0]              cmd_wdata;
    logic [128*ACT_BITS-1:0]  cmd_act;
    logic                     cmd_addr;
    logic                     cmd_wb;
    logic                     res_valid;
    logic                     res_ready;
    logic [64*ACT_BITS-1:0]   res_data;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_wdata, cmd_act, cmd_addr, cmd_wb, res_ready,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_wdata, cmd_act, cmd_addr, cmd_wb, res_ready,
        output cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/cim_macro_driver.sv
// Sequencer for the 64-column CIM macro: timed row writes and bit-serial
// compute with per-column shift accumulation of the sampled DOut planes.
module cim_acc_lane #(
    parameter int ACT_BITS = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic                i_d,
    output logic [ACT_BITS-1:0] o_acc
);
    logic [ACT_BITS-1:0] r_acc;
    logic [ACT_BITS-1:0] w_shift;

    generate
        if (ACT_BITS == 1) begin : g_one
            assign w_shift = i_d;
        end else begin : g_multi
            assign w_shift = {r_acc[ACT_BITS-2:0], i_d};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) r_acc <= '0;
        else if (i_en)      r_acc <= w_shift;
    end

    assign o_acc = r_acc;
endmodule

module cim_macro_driver #(
    parameter int ACT_BITS  = 4,
    parameter int MAC_LAT   = 1,
    parameter int WR_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    cim_macro_driver_if.slave    cmd,
    output logic                 o_busy,
    output logic                 o_we,
    output logic [63:0]          o_bl,
    output logic [63:0]          o_blb,
    output logic [127:0]         o_wl,
    output logic [127:0]         o_in_b,
    output logic                 o_addr,
    output logic                 o_wb,
    input  logic [63:0]          i_dout
);
    localparam int PW = (ACT_BITS > 1) ? $clog2(ACT_BITS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WREC, S_DRIVE, S_SAMPLE, S_RESP} state_t;

    state_t                          r_state, w_nxt;
    logic [2:0]                      r_cnt;
    logic [PW-1:0]                   r_plane;
    logic                            r_rdy_en;
    logic [6:0]                      r_row;
    logic [63:0]                     r_wdata;
    logic [ACT_BITS-1:0][127:0]      r_act;
    logic                            r_addr, r_wb;
    logic [63:0][ACT_BITS-1:0]       w_acc;
    logic                            w_accept, w_clr, w_smp;

    // cmd_ready stays low for the first cycle after reset, even though the FSM is idle
    assign cmd.cmd_ready = (r_state == S_IDLE) && r_rdy_en;
    assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;
    assign w_clr         = w_accept && cmd.cmd_op;
    assign w_smp         = (r_state == S_SAMPLE);
    assign o_busy        = (r_state != S_IDLE);
    assign cmd.res_valid = (r_state == S_RESP);
    assign cmd.res_data  = (r_state == S_RESP) ? w_acc : '0;
    assign o_addr        = r_addr;
    assign o_wb          = r_wb;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_plane  <= '0;
            r_rdy_en <= 1'b0;
            r_row    <= '0;
            r_wdata  <= '0;
            r_act    <= '0;
            r_addr   <= 1'b0;
            r_wb     <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_rdy_en <= 1'b1;
            r_cnt    <= (w_nxt != r_state) ? '0 : r_cnt + 1'b1;
            if (w_accept) begin
                r_row   <= cmd.cmd_row;
                r_wdata <= cmd.cmd_wdata;
                r_act   <= cmd.cmd_act;
                r_addr  <= cmd.cmd_addr;
                r_wb    <= cmd.cmd_wb;
                r_plane <= PW'(ACT_BITS-1);
            end else if (w_smp && r_plane != '0) begin
                r_plane <= r_plane - 1'b1;
            end
        end
    end

    always_comb begin
        w_nxt  = r_state;
        o_we   = 1'b0;
        o_wl   = '0;
        o_bl   = '0;
        o_blb  = '0;
        o_in_b = '0;
        case (r_state)
            S_IDLE:  if (w_accept) w_nxt = cmd.cmd_op ? S_DRIVE : S_WRITE;
            S_WRITE: begin
                o_we  = 1'b1;
                o_wl  = 128'd1 << r_row;
                o_bl  = r_wdata;
                o_blb = ~r_wdata;
                if (r_cnt == 3'(WR_CYCLES-1)) w_nxt = S_WREC;
            end
            S_WREC:  w_nxt = S_IDLE;
            S_DRIVE, S_SAMPLE: begin
                o_wl   = '1;
                o_in_b = r_act[r_plane];
                if (r_state == S_DRIVE) begin
                    if (r_cnt == 3'(MAC_LAT-1)) w_nxt = S_SAMPLE;
                end else begin
                    w_nxt = (r_plane == '0) ? S_RESP : S_DRIVE;
                end
            end
            S_RESP:  if (cmd.res_ready) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    for (genvar c = 0; c < 64; c++) begin : g_lane
        cim_acc_lane #(.ACT_BITS(ACT_BITS)) u_lane (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_clr (w_clr),
            .i_en  (w_smp),
            .i_d   (i_dout[c]),
            .o_acc (w_acc[c])
        );
    end
endmodule

// File: tb/tb_cim_macro_driver.sv
// Bench for cim_macro_driver: cycle-timeline reference model plus directed scenarios.
module tb_cim_macro_driver;
    localparam int A  = 4;
    localparam int L  = 1;
    localparam int W  = 2;
    localparam int NP = A * (L + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cim_macro_driver_if #(.ACT_BITS(A)) bus ();
    logic         busy, we, addr, wb;
    logic [63:0]  bl, blb;
    logic [63:0]  dout = 64'hDEAD_BEEF_0BAD_F00D;
    logic [127:0] wl, in_b;

    cim_macro_driver #(.ACT_BITS(A), .MAC_LAT(L), .WR_CYCLES(W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .cmd    (bus),
        .o_busy (busy),
        .o_we   (we),
        .o_bl   (bl),
        .o_blb  (blb),
        .o_wl   (wl),
        .o_in_b (in_b),
        .o_addr (addr),
        .o_wb   (wb),
        .i_dout (dout)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cyc%0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        vecs++;
        errs++;
        $display("FAIL %s: wait bound expired at cyc%0d", nm, cyc);
    endtask

    // Reference model: a command timeline measured in cycles from acceptance
    typedef enum {M_NONE, M_RST, M_IDLE, M_WR, M_CMP, M_RESP} mmode_t;
    mmode_t              m_mode = M_NONE;
    int                  cyc = 0;
    int                  t0 = 0;
    logic [6:0]          m_row;
    logic [63:0]         m_wdata;
    logic [A-1:0][127:0] m_act;
    logic                m_addr, m_wb;
    logic [63:0]         dtab   [A];
    logic [63:0]         m_dtab [A];

    // Column c result bit p is whatever the macro returned while plane p was driven
    function automatic logic [255:0] exp_res();
        logic [255:0] r = '0;
        for (int c = 0; c < 64; c++)
            for (int p = 0; p < A; p++)
                r[A*c+p] = m_dtab[p][c];
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_mode <= M_RST;
            m_addr <= 1'b0;
            m_wb   <= 1'b0;
        end else begin
            case (m_mode)
                M_RST:  m_mode <= M_IDLE;
                M_IDLE: if (bus.cmd_valid) begin
                    t0      <= cyc;
                    m_row   <= bus.cmd_row;
                    m_wdata <= bus.cmd_wdata;
                    m_act   <= bus.cmd_act;
                    m_addr  <= bus.cmd_addr;
                    m_wb    <= bus.cmd_wb;
                    m_dtab  <= dtab;
                    m_mode  <= bus.cmd_op ? M_CMP : M_WR;
                end
                M_WR:   if (cyc - t0 == W + 1) m_mode <= M_IDLE;
                M_CMP:  if (cyc - t0 == NP) m_mode <= M_RESP;
                M_RESP: if (bus.res_ready) m_mode <= M_IDLE;
                default: ;
            endcase
        end
    end

    int           n, k, p;
    logic         e_rdy, e_busy, e_we, e_rv, e_addr, e_wb;
    logic [127:0] e_wl, e_inb;
    logic [63:0]  e_bl, e_blb, nd;
    logic [255:0] e_rd;

    always @(negedge clk) begin
        if (m_mode != M_NONE) begin
            n = cyc - t0;
            e_rdy = 0; e_busy = 0; e_we = 0; e_rv = 0;
            e_wl = '0; e_inb = '0; e_bl = '0; e_blb = '0; e_rd = '0;
            e_addr = m_addr; e_wb = m_wb;
            nd = 64'hDEAD_BEEF_0BAD_F00D;
            case (m_mode)
                M_IDLE: e_rdy = 1;
                M_WR: begin
                    e_busy = 1;
                    if (n <= W) begin
                        e_we = 1; e_wl = 128'd1 << m_row; e_bl = m_wdata; e_blb = ~m_wdata;
                    end
                end
                M_CMP: begin
                    e_busy = 1;
                    k = (n - 1) / (L + 1);
                    p = A - 1 - k;
                    e_wl = '1;
                    e_inb = m_act[p];
                    // only the last cycle of each plane carries the real answer
                    nd = (n == (k + 1) * (L + 1)) ? m_dtab[p] : ~m_dtab[p];
                end
                M_RESP: begin
                    e_busy = 1; e_rv = 1; e_rd = exp_res();
                end
                default: ;
            endcase
            chk("cmd_ready", bus.cmd_ready, e_rdy);
            chk("busy", busy, e_busy);
            chk("WE", we, e_we);
            chk("WL", wl, e_wl);
            chk("BL", bl, e_bl);
            chk("BLB", blb, e_blb);
            chk("In_B", in_b, e_inb);
            chk("Addr", addr, e_addr);
            chk("wb", wb, e_wb);
            chk("res_valid", bus.res_valid, e_rv);
            chk("res_data", bus.res_data, e_rd);
            dout <= nd;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        int b = 0;
        while (cyc < c && b < 1000) begin step(); b++; end
    endtask

    task automatic issue(input logic op, input logic [6:0] row, input logic [63:0] wd,
                         input logic [128*A-1:0] act, input logic ad, input logic w,
                         output int tacc);
        int b = 0;
        while (m_mode != M_IDLE && b < 200) begin step(); b++; end
        if (m_mode != M_IDLE) expire("issue_wait");
        bus.cmd_valid = 1; bus.cmd_op = op; bus.cmd_row = row; bus.cmd_wdata = wd;
        bus.cmd_act = act; bus.cmd_addr = ad; bus.cmd_wb = w;
        tacc = cyc;
        step();
        bus.cmd_valid = 0; bus.cmd_row = ~row; bus.cmd_wdata = ~wd;
        bus.cmd_act = ~act; bus.cmd_addr = ~ad; bus.cmd_wb = ~w;
    endtask

    task automatic wait_resp();
        int b = 0;
        while (m_mode != M_RESP && b < 100) begin step(); b++; end
        if (m_mode != M_RESP) expire("resp_wait");
    endtask

    logic [128*A-1:0] act;
    logic [255:0]     e;
    int               t;

    initial begin
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_row = '0; bus.cmd_wdata = '0;
        bus.cmd_act = '0; bus.cmd_addr = 0; bus.cmd_wb = 0; bus.res_ready = 1;
        for (int i = 0; i < A; i++) dtab[i] = '0;

        // reset: 3 sampled high cycles, ready exactly one cycle after release
        repeat (3) @(posedge clk);
        step();
        rst = 0;
        chk("rst_ready_low", bus.cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        step();
        chk("rst_ready_up", bus.cmd_ready, 1'b1);

        // row write
        issue(0, 7'd5, 64'hA5A5_0000_FFFF_1234, '0, 1'b1, 1'b0, t);
        chk("wr_we1", we, 1'b1);
        chk("wr_wl", wl, 128'h20);
        chk("wr_bl", bl, 64'hA5A5_0000_FFFF_1234);
        chk("wr_blb", blb, 64'h5A5A_FFFF_0000_EDCB);
        goto(t + 2); chk("wr_we2", we, 1'b1);
        goto(t + 3); chk("wrec_we", we, 1'b0); chk("wrec_wl", wl, 128'h0);
        goto(t + 4); chk("wr_ready_t4", bus.cmd_ready, 1'b1); chk("wr_addr_hold", addr, 1'b1);

        // compute 1010 pattern, MSB plane first
        dtab[3] = '1; dtab[2] = '0; dtab[1] = '1; dtab[0] = '0;
        act = {128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, {4{32'hCAFE_F00D}},
               {8{16'h5A5A}}, 128'h1};
        issue(1, 7'd0, '0, act, 1'b0, 1'b1, t);
        chk("cmp_inb_p3", in_b, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        goto(t + 3); chk("cmp_inb_p2", in_b, {4{32'hCAFE_F00D}});
        goto(t + 5); chk("cmp_inb_p1", in_b, {8{16'h5A5A}});
        goto(t + 7); chk("cmp_inb_p0", in_b, 128'h1);
        goto(t + 8); chk("cmp_rv_t8", bus.res_valid, 1'b0);
        goto(t + 9); chk("cmp_rv_t9", bus.res_valid, 1'b1);
        chk("cmp_res", bus.res_data, {64{4'b1010}});
        goto(t + 10); chk("cmp_ready_after", bus.cmd_ready, 1'b1);

        // backpressure: ten stalled RESP cycles
        dtab[3] = 64'h0123_4567_89AB_CDEF; dtab[2] = 64'hFEDC_BA98_7654_3210;
        dtab[1] = 64'hFFFF_0000_FFFF_0000; dtab[0] = 64'h0000_0000_FFFF_FFFF;
        bus.res_ready = 0;
        issue(1, 7'd0, '0, {A{128'hF0F0}}, 1'b1, 1'b1, t);
        wait_resp();
        for (int i = 0; i < 10; i++) begin
            chk("bp_ready_low", bus.cmd_ready, 1'b0);
            step();
        end
        bus.res_ready = 1;
        chk("bp_rv_held", bus.res_valid, 1'b1);
        step();
        chk("bp_idle_busy", busy, 1'b0);
        chk("bp_idle_ready", bus.cmd_ready, 1'b1);

        // reset during the second plane's drive
        dtab[3] = '1; dtab[2] = '1; dtab[1] = '1; dtab[0] = '1;
        issue(1, 7'd0, '0, {A{128'h1234}}, 1'b1, 1'b0, t);
        goto(t + 3);
        rst = 1;
        step();
        rst = 0;
        chk("mr_inb", in_b, 128'h0);
        chk("mr_wl", wl, 128'h0);
        chk("mr_rv", bus.res_valid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        dtab[3] = '0; dtab[2] = '0; dtab[1] = '0; dtab[0] = '1;
        issue(1, 7'd0, '0, {A{128'h55}}, 1'b0, 1'b0, t);
        wait_resp();
        chk("mr_res", bus.res_data, {64{4'b0001}});

        // column mapping: column 0 then column 63
        for (int i = 0; i < A; i++) dtab[i] = 64'h1;
        issue(1, 7'd0, '0, {A{128'hAA}}, 1'b0, 1'b0, t);
        wait_resp();
        chk("col0_res", bus.res_data, 256'hF);
        for (int i = 0; i < A; i++) dtab[i] = 64'h8000_0000_0000_0000;
        issue(1, 7'd0, '0, {A{128'hBB}}, 1'b0, 1'b0, t);
        wait_resp();
        e = '0;
        e[255:252] = 4'hF;
        chk("col63_res", bus.res_data, e);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
